etx_arbiter: RTL and testbench
==============================

# etx_arbiter

Transmit-side arbiter of the elink: merges the three transmit FIFO outputs (write, read request, read response) into a single registered packet stream toward the elink TX IO serializer. It is the transmit-path counterpart of the receive distributor that splits incoming traffic into the same three queues. Read responses have priority, reads and writes share bandwidth round-robin, and sequential double-word write bursts are kept unbroken on the link.

## Interface
- PW, 104, packet width. Layout: [0] write, [2:1] datamode, [6:3] ctrlmode, [39:8] dstaddr, [71:40] data, [103:72] srcaddr
- MAXBURST, 16, maximum write packets per locked burst (2..256)
- clk  in  1  transmit core clock
- nreset  in  1  asynchronous active-low reset
- txwr_access  in  1  write FIFO packet valid
- txwr_packet  in  PW  write FIFO packet
- txwr_wait  out  1  write FIFO stall
- txrd_access  in  1  read-request FIFO packet valid
- txrd_packet  in  PW  read-request FIFO packet
- txrd_wait  out  1  read-request FIFO stall
- txrr_access  in  1  read-response FIFO packet valid
- txrr_packet  in  PW  read-response FIFO packet
- txrr_wait  out  1  read-response FIFO stall
- etx_rd_wait  in  1  IO pushback for read requests (write bit 0)
- etx_wr_wait  in  1  IO pushback for writes and read responses (write bit 1)
- etx_access  out  1  registered packet valid to IO
- etx_packet  out  PW  registered packet to IO
- etx_burst  out  1  burst lock active (registered)

## Operation
- Transfer on a source port: access & ~wait in the same cycle. A source holds access/packet stable while wait is high.
- stall = etx_access & (etx_packet[0] ? etx_wr_wait : etx_rd_wait). Output register loads when ~stall. Otherwise etx_access/etx_packet hold.
- The arbiter grants only when ~stall. txX_wait = ~grant_X, so every wait is high when stalled or not granted.
- Grant order when not locked: txrr first. Otherwise, between txrd and txwr, the port indicated by the round-robin pointer rr_ptr (0 = wr, 1 = rd) wins if it requests; if not, the other port wins.
- rr_ptr toggles after every rd or wr transfer, pointing away from the port just served. It is unchanged by rr transfers.
- Lock FSM has two states, IDLE and BURST.
  - IDLE -> BURST: on a wr transfer with datamode == 2'b11. Record dstaddr and set burst count cnt = 1.
  - In BURST, wr is the only grantable port. This preempts rr and rd.
  - A wr packet continues the burst if txwr_access, datamode == 2'b11, dstaddr == last_dstaddr + 8 (32-bit wrap), and cnt < MAXBURST. Each continuing transfer updates last_dstaddr and increments cnt.
  - BURST -> IDLE in the first non-stalled cycle in which the txwr packet does not continue the burst. Normal arbitration applies in that same cycle.
  - While stalled, the FSM holds its state.
- Reaching cnt == MAXBURST ends the lock. A following sequential wr packet may start a new burst only if it wins normal arbitration.
- When nothing is granted and ~stall, etx_access loads 0.
- All packets pass through bit-exact. The block does no address filtering.

## Timing
- Reset (nreset low, asynchronous): etx_access = 0, etx_packet = 0, etx_burst = 0, FSM = IDLE, rr_ptr = 0, cnt = 0. All txX_wait are high while nreset is low.
- Latency: one cycle from source transfer to etx_access/etx_packet.
- Full throughput: one packet per cycle when no stall.
- etx_burst goes high in the cycle after the burst-opening transfer and low in the cycle after the lock ends.
- Reset mid-burst drops the lock and the output packet. Upstream retains packets that were not yet transferred.
- Simultaneous events:
  - All three request: rr wins.
  - rd and wr request, rr_ptr = 0: wr wins, then rd on the next cycle.
  - etx_wr_wait with a read request pending is not a stall, unless the held packet is a write.

## Test plan
- After reset, txrr, txrd and txwr all request on one cycle, no IO wait -> etx_packet order is rr, wr, rd. Waits are asserted accordingly. etx_access is continuous.
- Alternating rd and wr requests held high for 8 cycles -> the output alternates wr, rd, wr, ... with exactly 4 of each.
- Write burst: 5 double writes at dstaddr 0x80800000, +8, ... with rr requesting throughout -> 5 consecutive wr packets, etx_burst high for 5 cycles, then rr is sent.
- MAXBURST = 4 with 6 sequential double writes and a pending rd -> 4 wr, then rd, then the remaining 2 wr.
- Held write packet with etx_wr_wait high for 3 cycles -> etx_packet is stable, all txX_wait are high, nothing is lost. The next packet appears 1 cycle after the wait drops.
- nreset pulsed low mid-burst -> etx_access and etx_burst go to 0 immediately. After release, arbitration restarts with rr_ptr = 0.

Source files
------------

// File: rtl/etx_arbiter.sv
// etx_arbiter: transmit-side arbiter of the elink.
// Merges the write, read-request and read-response FIFO outputs into one
// registered packet stream toward the TX IO serializer. Read responses win,
// reads and writes alternate round-robin, and sequential double-word write
// bursts are held together on the link by a two-state lock.
module etx_arbiter #(
   parameter int PW       = 104,
   parameter int MAXBURST = 16
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          txwr_access,
   input  logic [PW-1:0] txwr_packet,
   output logic          txwr_wait,
   input  logic          txrd_access,
   input  logic [PW-1:0] txrd_packet,
   output logic          txrd_wait,
   input  logic          txrr_access,
   input  logic [PW-1:0] txrr_packet,
   output logic          txrr_wait,
   input  logic          etx_rd_wait,
   input  logic          etx_wr_wait,
   output logic          etx_access,
   output logic [PW-1:0] etx_packet,
   output logic          etx_burst
);

   // Lock FSM encoding.
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   // Burst counter must hold the value MAXBURST itself.
   localparam int CW = $clog2(MAXBURST + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAXBURST);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   // Registered state.
   logic [0:0]    state_r;
   logic [31:0]   last_addr_r;
   logic [CW-1:0] cnt_r;
   logic          rr_ptr_r;
   logic          etx_access_r;
   logic [PW-1:0] etx_packet_r;

   // Combinational decisions for the current cycle.
   logic          stall_s;
   logic          wr_double_s;
   logic          wr_seq_s;
   logic          burst_cont_s;
   logic          grant_wr_s;
   logic          grant_rd_s;
   logic          grant_rr_s;
   logic          grant_any_s;
   logic [PW-1:0] sel_packet_s;
   logic [0:0]    state_nxt_s;
   logic [31:0]   last_addr_nxt_s;
   logic [CW-1:0] cnt_nxt_s;

   // A held output packet stalls only against the IO wait of its own class.
   assign stall_s = etx_access_r & (etx_packet_r[0] ? etx_wr_wait : etx_rd_wait);

   // Double-word write at the next sequential address keeps the burst alive.
   assign wr_double_s  = (txwr_packet[2:1] == 2'b11);
   assign wr_seq_s     = (txwr_packet[39:8] == (last_addr_r + 32'd8));
   assign burst_cont_s = (state_r == ST_BURST) & txwr_access & wr_double_s &
                         wr_seq_s & (cnt_r < CNT_MAX);

   // Grant selection: burst lock first, then rr, then the round-robin pair.
   always_comb begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
      grant_rr_s = 1'b0;
      if (!nreset || stall_s) begin
         grant_wr_s = 1'b0;
      end else if (burst_cont_s) begin
         grant_wr_s = 1'b1;
      end else if (txrr_access) begin
         grant_rr_s = 1'b1;
      end else if (txrd_access && txwr_access) begin
         if (rr_ptr_r) begin
            grant_rd_s = 1'b1;
         end else begin
            grant_wr_s = 1'b1;
         end
      end else if (txrd_access) begin
         grant_rd_s = 1'b1;
      end else if (txwr_access) begin
         grant_wr_s = 1'b1;
      end else begin
         grant_wr_s = 1'b0;
      end
   end

   assign grant_any_s = grant_wr_s | grant_rd_s | grant_rr_s;

   // Every source is stalled unless it holds the grant this cycle.
   assign txwr_wait = ~grant_wr_s;
   assign txrd_wait = ~grant_rd_s;
   assign txrr_wait = ~grant_rr_s;

   // Route the granted source's packet toward the output register.
   always_comb begin
      sel_packet_s = txwr_packet;
      if (grant_rr_s) begin
         sel_packet_s = txrr_packet;
      end else if (grant_rd_s) begin
         sel_packet_s = txrd_packet;
      end else begin
         sel_packet_s = txwr_packet;
      end
   end

   // Lock FSM next state: continue, open a fresh burst, or fall back to idle.
   always_comb begin
      state_nxt_s     = state_r;
      last_addr_nxt_s = last_addr_r;
      cnt_nxt_s       = cnt_r;
      if (stall_s) begin
         state_nxt_s = state_r;
      end else if (burst_cont_s) begin
         state_nxt_s     = ST_BURST;
         last_addr_nxt_s = txwr_packet[39:8];
         cnt_nxt_s       = cnt_r + CNT_ONE;
      end else if (grant_wr_s && wr_double_s) begin
         // The lock ended (or was idle) and a double write won normal
         // arbitration: it opens a new burst.
         state_nxt_s     = ST_BURST;
         last_addr_nxt_s = txwr_packet[39:8];
         cnt_nxt_s       = CNT_ONE;
      end else begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = '0;
      end
   end

   // Lock FSM, burst address tracker and burst counter.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r     <= ST_IDLE;
         last_addr_r <= 32'd0;
         cnt_r       <= '0;
      end else begin
         state_r     <= state_nxt_s;
         last_addr_r <= last_addr_nxt_s;
         cnt_r       <= cnt_nxt_s;
      end
   end

   // Round-robin pointer moves away from whichever of rd/wr was just served.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rr_ptr_r <= 1'b0;
      end else if (grant_rd_s) begin
         rr_ptr_r <= 1'b0;
      end else if (grant_wr_s) begin
         rr_ptr_r <= 1'b1;
      end
   end

   // Output register: loads when not stalled, holds otherwise.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         etx_access_r <= 1'b0;
         etx_packet_r <= '0;
      end else if (!stall_s) begin
         etx_access_r <= grant_any_s;
         if (grant_any_s) begin
            etx_packet_r <= sel_packet_s;
         end
      end
   end

   assign etx_access = etx_access_r;
   assign etx_packet = etx_packet_r;
   assign etx_burst  = state_r;

endmodule

// File: tb/tb_etx_arbiter.sv
// Self-checking bench for etx_arbiter. A transaction-level model (queues for
// the three sources, a few scalar variables for the lock and the pointer)
// predicts outputs and waits each cycle; directed scenarios pin the model
// with hand-written packet orders. Two DUTs (MAXBURST 16 and 4) share the
// inputs; 'sel' picks the one being checked.
module tb_etx_arbiter;
   localparam int PW = 104;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   logic txwr_access = 1'b0, txrd_access = 1'b0, txrr_access = 1'b0;
   logic [PW-1:0] txwr_packet = '0, txrd_packet = '0, txrr_packet = '0;
   logic etx_rd_wait = 1'b0, etx_wr_wait = 1'b0;

   logic a_wr_wait, a_rd_wait, a_rr_wait, a_access, a_burst;
   logic b_wr_wait, b_rd_wait, b_rr_wait, b_access, b_burst;
   logic [PW-1:0] a_packet, b_packet;

   etx_arbiter #(.PW(PW), .MAXBURST(16)) dut_a (
      .clk(clk), .nreset(nreset),
      .txwr_access(txwr_access), .txwr_packet(txwr_packet), .txwr_wait(a_wr_wait),
      .txrd_access(txrd_access), .txrd_packet(txrd_packet), .txrd_wait(a_rd_wait),
      .txrr_access(txrr_access), .txrr_packet(txrr_packet), .txrr_wait(a_rr_wait),
      .etx_rd_wait(etx_rd_wait), .etx_wr_wait(etx_wr_wait),
      .etx_access(a_access), .etx_packet(a_packet), .etx_burst(a_burst));

   etx_arbiter #(.PW(PW), .MAXBURST(4)) dut_b (
      .clk(clk), .nreset(nreset),
      .txwr_access(txwr_access), .txwr_packet(txwr_packet), .txwr_wait(b_wr_wait),
      .txrd_access(txrd_access), .txrd_packet(txrd_packet), .txrd_wait(b_rd_wait),
      .txrr_access(txrr_access), .txrr_packet(txrr_packet), .txrr_wait(b_rr_wait),
      .etx_rd_wait(etx_rd_wait), .etx_wr_wait(etx_wr_wait),
      .etx_access(b_access), .etx_packet(b_packet), .etx_burst(b_burst));

   always #5 clk = ~clk;

   bit sel = 1'b0;
   logic act_wr_wait, act_rd_wait, act_rr_wait, act_access, act_burst;
   logic [PW-1:0] act_packet;
   assign act_wr_wait = sel ? b_wr_wait : a_wr_wait;
   assign act_rd_wait = sel ? b_rd_wait : a_rd_wait;
   assign act_rr_wait = sel ? b_rr_wait : a_rr_wait;
   assign act_access  = sel ? b_access  : a_access;
   assign act_burst   = sel ? b_burst   : a_burst;
   assign act_packet  = sel ? b_packet  : a_packet;

   // Source queues (front = packet currently offered).
   logic [PW-1:0] q_wr[$];
   logic [PW-1:0] q_rd[$];
   logic [PW-1:0] q_rr[$];

   // Model state.
   bit            m_acc;
   logic [PW-1:0] m_pkt;
   bit            m_burst;
   logic [31:0]   m_last;
   int            m_cnt;
   bit            m_ptr;
   bit            prev_nostall;

   typedef struct {int c; int tag; int seq;} ent_t;
   ent_t lg[$];

   int cyc = 0;
   int seq_n = 0;
   int burst_cycles = 0;
   int pass_cnt = 0;
   int total_cnt = 0;
   bit rdw_set = 1'b0, wrw_set = 1'b0;

   // tags: 1 = wr, 2 = rd, 3 = rr
   function automatic logic [PW-1:0] mk(int src, int seq, logic [1:0] dm, logic [31:0] addr);
      logic [PW-1:0] p;
      logic [7:0]    s8;
      logic [23:0]   q24;
      p = '0;
      s8 = src[7:0];
      q24 = seq[23:0];
      p[0] = (src != 2);
      p[2:1] = dm;
      p[6:3] = 4'($urandom_range(0, 15));
      p[39:8] = addr;
      p[71:40] = {s8, q24};
      p[103:72] = $urandom;
      return p;
   endfunction

   task automatic check(string nm, logic [127:0] got, logic [127:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
   endtask

   task automatic model_reset();
      m_acc = 1'b0; m_pkt = '0; m_burst = 1'b0; m_last = 32'd0;
      m_cnt = 0; m_ptr = 1'b0; prev_nostall = 1'b0;
   endtask

   // Which source must get this cycle (0 = none).
   task automatic model_grant(output int g, output bit st, output bit ct);
      int mb;
      mb = sel ? 4 : 16;
      st = m_acc && (m_pkt[0] ? etx_wr_wait : etx_rd_wait);
      ct = m_burst && txwr_access && (txwr_packet[2:1] == 2'b11) &&
           (txwr_packet[39:8] == m_last + 32'd8) && (m_cnt < mb);
      g = 0;
      if (!st) begin
         if (ct) g = 1;
         else if (txrr_access) g = 3;
         else if (txrd_access && txwr_access) g = m_ptr ? 2 : 1;
         else if (txrd_access) g = 2;
         else if (txwr_access) g = 1;
      end
   endtask

   task automatic model_update(int g, bit st, bit ct);
      if (!st) begin
         m_acc = (g != 0);
         if (g == 1) m_pkt = txwr_packet;
         else if (g == 2) m_pkt = txrd_packet;
         else if (g == 3) m_pkt = txrr_packet;
         if (g == 1) m_ptr = 1'b1;
         else if (g == 2) m_ptr = 1'b0;
         if (ct) begin
            m_last = txwr_packet[39:8];
            m_cnt++;
         end else if (g == 1 && txwr_packet[2:1] == 2'b11) begin
            m_burst = 1'b1; m_last = txwr_packet[39:8]; m_cnt = 1;
         end else begin
            m_burst = 1'b0; m_cnt = 0;
         end
      end
   endtask

   // One clock cycle: compare registered outputs, drive sources, compare waits.
   task automatic step();
      int g;
      bit st, ct, pw, pd, pr;
      @(negedge clk);
      check("etx_access", act_access, m_acc);
      check("etx_packet", act_packet, m_pkt);
      check("etx_burst", act_burst, m_burst);
      if (act_access && prev_nostall)
         lg.push_back('{cyc, int'(act_packet[71:64]), int'(act_packet[63:40])});
      if (act_burst) burst_cycles++;
      txwr_access = (q_wr.size() > 0);
      txwr_packet = txwr_access ? q_wr[0] : '0;
      txrd_access = (q_rd.size() > 0);
      txrd_packet = txrd_access ? q_rd[0] : '0;
      txrr_access = (q_rr.size() > 0);
      txrr_packet = txrr_access ? q_rr[0] : '0;
      etx_rd_wait = rdw_set;
      etx_wr_wait = wrw_set;
      #1;
      model_grant(g, st, ct);
      check("tx_wait{rr,rd,wr}", {act_rr_wait, act_rd_wait, act_wr_wait},
            {g != 3, g != 2, g != 1});
      pw = txwr_access && !act_wr_wait;
      pd = txrd_access && !act_rd_wait;
      pr = txrr_access && !act_rr_wait;
      @(posedge clk);
      model_update(g, st, ct);
      prev_nostall = !st;
      if (pw) void'(q_wr.pop_front());
      if (pd) void'(q_rd.pop_front());
      if (pr) void'(q_rr.pop_front());
      cyc++;
   endtask

   // Asynchronous reset pulse starting mid-cycle.
   task automatic do_reset();
      #2 nreset = 1'b0;
      #1;
      check("rst etx_access", act_access, 1'b0);
      check("rst etx_burst", act_burst, 1'b0);
      check("rst etx_packet", act_packet, '0);
      check("rst tx_wait", {act_rr_wait, act_rd_wait, act_wr_wait}, 3'b111);
      repeat (2) @(posedge clk);
      #1 nreset = 1'b1;
      model_reset();
   endtask

   task automatic clear_all();
      q_wr.delete(); q_rd.delete(); q_rr.delete();
      rdw_set = 1'b0; wrw_set = 1'b0;
   endtask

   task automatic expect_tags(string nm, int e[$]);
      check({nm, " count"}, lg.size(), e.size());
      for (int i = 0; i < e.size() && i < lg.size(); i++)
         check({nm, " src"}, lg[i].tag, e[i]);
   endtask

   initial begin
      int e[$];
      int n;
      logic [31:0] base;
      model_reset();

      // A: all three request at once -> rr, wr, rd back to back.
      sel = 1'b0; clear_all(); do_reset();
      q_rr.push_back(mk(3, 0, 2'b00, 32'h100));
      q_rd.push_back(mk(2, 0, 2'b00, 32'h200));
      q_wr.push_back(mk(1, 0, 2'b00, 32'h300));
      lg.delete();
      repeat (6) step();
      e = '{3, 1, 2}; expect_tags("order all3", e);
      if (lg.size() == 3) begin
         check("all3 contiguous 1", lg[1].c - lg[0].c, 1);
         check("all3 contiguous 2", lg[2].c - lg[1].c, 1);
      end

      // B: rd and wr held high -> wr, rd alternating, 4 each.
      clear_all(); do_reset();
      for (int i = 0; i < 4; i++) begin
         q_rd.push_back(mk(2, i, 2'b10, 32'h1000 + 32'(i)));
         q_wr.push_back(mk(1, i, 2'b10, 32'h2000 + 32'(i)));
      end
      lg.delete();
      repeat (10) step();
      e = '{1, 2, 1, 2, 1, 2, 1, 2}; expect_tags("alternate", e);

      // C: 5 sequential double writes, rr arriving behind the first one.
      clear_all(); do_reset();
      for (int i = 0; i < 5; i++)
         q_wr.push_back(mk(1, i, 2'b11, 32'h80800000 + 32'(8 * i)));
      lg.delete(); burst_cycles = 0;
      step();
      for (int i = 0; i < 3; i++) q_rr.push_back(mk(3, i, 2'b00, 32'h0));
      repeat (10) step();
      e = '{1, 1, 1, 1, 1, 3, 3, 3}; expect_tags("burst5", e);
      check("burst5 etx_burst cycles", burst_cycles, 5);

      // D: MAXBURST = 4, 6 sequential double writes and a pending read.
      sel = 1'b1; clear_all(); do_reset();
      for (int i = 0; i < 6; i++)
         q_wr.push_back(mk(1, i, 2'b11, 32'h40000000 + 32'(8 * i)));
      q_rd.push_back(mk(2, 0, 2'b00, 32'h0));
      lg.delete();
      repeat (10) step();
      e = '{1, 1, 1, 1, 2, 1, 1}; expect_tags("maxburst4", e);
      if (lg.size() == 7) check("maxburst4 resume seq", lg[5].seq, 4);

      // E: held write stalled by etx_wr_wait for 3 cycles.
      sel = 1'b0; clear_all(); do_reset();
      q_wr.push_back(mk(1, 0, 2'b00, 32'h10));
      q_wr.push_back(mk(1, 1, 2'b00, 32'h20));
      q_rd.push_back(mk(2, 0, 2'b00, 32'h30));
      lg.delete();
      for (int i = 0; i < 9; i++) begin
         wrw_set = (i >= 1 && i <= 3);
         step();
      end
      wrw_set = 1'b0;
      e = '{1, 2, 1}; expect_tags("stall", e);
      if (lg.size() == 3) check("stall gap", lg[1].c - lg[0].c, 4);

      // F: reset mid-burst, then arbitration restarts with pointer at wr.
      clear_all(); do_reset();
      for (int i = 0; i < 6; i++)
         q_wr.push_back(mk(1, i, 2'b11, 32'h80800000 + 32'(8 * i)));
      repeat (3) step();
      #1 check("burst before reset", act_burst, 1'b1);
      do_reset();
      q_rd.push_back(mk(2, 0, 2'b00, 32'h0));
      lg.delete();
      repeat (8) step();
      e = '{1, 1, 1, 2}; expect_tags("after reset", e);
      if (lg.size() > 0) check("after reset first seq", lg[0].seq, 3);

      // Random traffic on both configurations.
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1); clear_all(); do_reset();
         for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 9) == 0 && q_rr.size() < 4)
               q_rr.push_back(mk(3, seq_n++, 2'($urandom), $urandom));
            if ($urandom_range(0, 3) == 0 && q_rd.size() < 4)
               q_rd.push_back(mk(2, seq_n++, 2'($urandom), $urandom));
            if (q_wr.size() == 0 && $urandom_range(0, 2) == 0) begin
               if ($urandom_range(0, 1) == 1) begin
                  n = $urandom_range(2, 20);
                  base = $urandom & 32'hFFFF_FFF8;
                  for (int i = 0; i < n; i++) begin
                     if ($urandom_range(0, 15) == 0) base = base + 32'd16;
                     else base = base + 32'd8;
                     q_wr.push_back(mk(1, seq_n++, 2'b11, base));
                  end
               end else begin
                  q_wr.push_back(mk(1, seq_n++, 2'($urandom), $urandom));
               end
            end
            rdw_set = ($urandom_range(0, 4) == 0);
            wrw_set = ($urandom_range(0, 4) == 0);
            step();
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
